// File: rtl/diff_macc_accumulator_pkg.sv
// Shared definitions for the differential MACC accumulator: network-type
// decoding, event field layout and signed saturation bounds.
package diff_macc_accumulator_pkg;

  localparam int unsigned MAX_AW = 64;

  // Sub-field width: "cbm" carries only a negate bit, "rc" adds a double bit.
  function automatic int unsigned sw_of(input logic [31:0] net_type);
    return (net_type == 32'("cbm")) ? 1 : 2;
  endfunction

  function automatic int unsigned addr_w(input int unsigned na);
    return (na > 1) ? $clog2(na) : 1;
  endfunction

  function automatic int unsigned sub_lsb(input int unsigned ab);
    return ab;
  endfunction

  function automatic int unsigned last_bit(input int unsigned ab, input int unsigned sw);
    return ab + sw;
  endfunction

  function automatic int unsigned leap_bit(input int unsigned ab, input int unsigned sw);
    return ab + sw + 1;
  endfunction

  function automatic int unsigned ev_w(input int unsigned ab, input int unsigned sw);
    return ab + sw + 2;
  endfunction

  function automatic logic [MAX_AW-1:0] sat_max(input int unsigned aw);
    return (64'd1 << (aw - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_AW-1:0] sat_min(input int unsigned aw);
    return ~sat_max(aw);
  endfunction

endpackage

// File: rtl/diff_macc_accumulator_if.sv
// Event-in / snapshot-out handshake bundle of the accumulator.
interface diff_macc_accumulator_if #(
  parameter int DW = 6,
  parameter int AW = 16
);
  logic          iValid_AS;
  logic          oReady_AS;
  logic [DW-1:0] iData_AS;
  logic          oValid_BS;
  logic          iReady_BS;
  logic [AW-1:0] oData_BS;

  modport master (
    output iValid_AS, iData_AS, iReady_BS,
    input  oReady_AS, oValid_BS, oData_BS
  );

  modport slave (
    input  iValid_AS, iData_AS, iReady_BS,
    output oReady_AS, oValid_BS, oData_BS
  );
endinterface

// File: rtl/diff_macc_accumulator_sat_add.sv
// AW-bit signed adder that clamps to the representable range instead of wrapping.
module sat_add #(
  parameter int AW = 16
) (
  input  logic signed [AW-1:0] a_i,
  input  logic signed [AW-1:0] b_i,
  output logic signed [AW-1:0] sum_o
);
  import diff_macc_accumulator_pkg::*;

  localparam logic [MAX_AW-1:0] MAX64 = sat_max(AW);
  localparam logic [MAX_AW-1:0] MIN64 = sat_min(AW);
  localparam logic [AW-1:0]     MAX_P = MAX64[AW-1:0];
  localparam logic [AW-1:0]     MIN_N = MIN64[AW-1:0];

  logic [AW:0] wide;

  always_comb begin
    wide = {a_i[AW-1], a_i} + {b_i[AW-1], b_i};
    // Top two bits disagree only on overflow; the guard bit holds the true sign.
    if (wide[AW] != wide[AW-1]) begin
      sum_o = wide[AW] ? MIN_N : MAX_P;
    end else begin
      sum_o = wide[AW-1:0];
    end
  end
endmodule

// File: rtl/diff_macc_accumulator.sv
// Differential multiply-accumulate: one-stage event buffer feeding a saturating
// accumulator, with a registered snapshot emitted at every step end.
module diff_macc_accumulator #(
  parameter int NA   = 4,
  parameter     TYPE = "rc",
  parameter int WW   = 8,
  parameter int AW   = 16
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [NA*WW-1:0]     iWeight,
  diff_macc_accumulator_if.slave bus
);
  import diff_macc_accumulator_pkg::*;

  localparam int unsigned SW   = sw_of(32'(TYPE));
  localparam int unsigned AB   = addr_w(NA);
  localparam int unsigned SUBL = sub_lsb(AB);
  localparam int unsigned LAST = last_bit(AB, SW);
  localparam int unsigned LEAP = leap_bit(AB, SW);

  logic [AB-1:0]        ev_addr;
  logic [1:0]           ev_sub;
  logic                 ev_last;
  logic                 ev_leap;
  logic signed [WW-1:0] w_sel;
  logic signed [AW-1:0] w_ext;
  logic signed [AW-1:0] delta_new;

  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_end_q, s1_end_d;
  logic signed [AW-1:0] s1_delta_q, s1_delta_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 out_vld_q, out_vld_d;
  logic signed [AW-1:0] out_data_q, out_data_d;
  logic signed [AW-1:0] acc_sum;

  logic stall;
  logic ready;
  logic accept;
  logic consume;

  always_comb begin
    ev_addr          = bus.iData_AS[AB-1:0];
    ev_sub           = '0;
    ev_sub[SW-1:0]   = bus.iData_AS[SUBL +: SW];
    ev_last          = bus.iData_AS[LAST];
    ev_leap          = bus.iData_AS[LEAP];
    w_sel            = iWeight[int'(ev_addr)*WW +: WW];
    w_ext            = {{(AW-WW){w_sel[WW-1]}}, w_sel};
    delta_new        = w_ext;
    if (ev_sub[0]) delta_new = -w_ext;
    if (SW == 2 && ev_sub[1]) delta_new = delta_new <<< 1;
    if (ev_leap) delta_new = '0;
  end

  always_comb begin
    stall   = s1_vld_q && s1_end_q && out_vld_q && !bus.iReady_BS;
    ready   = !iRST && (!s1_vld_q || !stall);
    accept  = bus.iValid_AS && ready;
    consume = s1_vld_q && !stall;
  end

  sat_add #(.AW(AW)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (s1_delta_q),
    .sum_o (acc_sum)
  );

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_end_d   = s1_end_q;
    s1_delta_d = s1_delta_q;
    acc_d      = acc_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    if (consume) begin
      acc_d    = acc_sum;
      s1_vld_d = 1'b0;
    end
    if (accept) begin
      s1_vld_d   = 1'b1;
      s1_end_d   = ev_leap | ev_last;
      s1_delta_d = delta_new;
    end
    // A drain and a fresh load on the same edge keep valid high throughout.
    if (out_vld_q && bus.iReady_BS) out_vld_d = 1'b0;
    if (consume && s1_end_q) begin
      out_vld_d  = 1'b1;
      out_data_d = acc_sum;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_vld_q   <= 1'b0;
      s1_end_q   <= 1'b0;
      s1_delta_q <= '0;
      acc_q      <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_end_q   <= s1_end_d;
      s1_delta_q <= s1_delta_d;
      acc_q      <= acc_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    bus.oReady_AS = ready;
    bus.oValid_BS = out_vld_q;
    bus.oData_BS  = out_data_q;
  end
endmodule
